mem_wb_stage: RTL and testbench

- Pipeline register and write-back select between the Memory stage and the 128-entry x 128-bit register file.
- Captures the Memory-stage result (ALU result or data-memory read data) together with the destination register and write enable.
- Presents a single registered write port to the register file.
- Supports stall and flush from the hazard unit and keeps a saturating retired-instruction counter for performance monitoring.

---
 rtl/spu_pkg.sv | 8 +
 rtl/sat_counter.sv | 16 +
 rtl/mem_wb_stage.sv | 55 +++++
 tb/tb_mem_wb_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared SPU datapath constants and types, common to the Execute, Memory and Write-back stage registers.
package spu_pkg;
  localparam int DATA_W = 128;
  localparam int REG_W  = 7;

  typedef logic [DATA_W-1:0] quadword_t;
  typedef logic [REG_W-1:0]  reg_addr_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear, for performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (!clr_n)
      count <= '0;
    else if (en && (count != {CNT_W{1'b1}}))
      count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the write-back data and drives the single register-file write port.
module mem_wb_stage #(
  parameter int DATA_W = spu_pkg::DATA_W,
  parameter int REG_W  = spu_pkg::REG_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              regWrite_in,
  input  logic              memToReg_in,
  input  logic [REG_W-1:0]  registerRT_in,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic [DATA_W-1:0] Mem_readData,
  output logic              wb_valid,
  output logic              wb_regWrite,
  output logic [REG_W-1:0]  wb_registerRT,
  output logic [DATA_W-1:0] wb_writeData,
  output logic [CNT_W-1:0]  retired_count
);
  logic [DATA_W-1:0] wr_data;
  logic              retire;

  assign wr_data = memToReg_in ? Mem_readData : ALU_Result;
  assign retire  = !stall && !flush && in_valid;

  // Address/data still load on flush so the port contents stay deterministic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid      <= 1'b0;
      wb_regWrite   <= 1'b0;
      wb_registerRT <= '0;
      wb_writeData  <= '0;
    end else if (!stall) begin
      if (flush) begin
        wb_valid    <= 1'b0;
        wb_regWrite <= 1'b0;
      end else begin
        wb_valid    <= in_valid;
        wb_regWrite <= in_valid & regWrite_in;
      end
      wb_registerRT <= registerRT_in;
      wb_writeData  <= wr_data;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_retired (
    .clk   (clk),
    .clr_n (reset),
    .en    (retire),
    .count (retired_count)
  );
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; a second instance with CNT_W=4 shares the stimulus to reach saturation.
module tb_mem_wb_stage;
  localparam int DATA_W = 128;
  localparam int REG_W  = 7;

  logic              clk = 1'b0;
  logic              reset, stall, flush, in_valid, regWrite_in, memToReg_in;
  logic [REG_W-1:0]  registerRT_in;
  logic [DATA_W-1:0] ALU_Result, Mem_readData;
  logic              wb_valid, wb_regWrite;
  logic [REG_W-1:0]  wb_registerRT;
  logic [DATA_W-1:0] wb_writeData;
  logic [31:0]       retired_count;
  logic              s_valid, s_regWrite;
  logic [REG_W-1:0]  s_registerRT;
  logic [DATA_W-1:0] s_writeData;
  logic [3:0]        s_count;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] pat_a5, pat_12, pat_x1, pat_x2;

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .regWrite_in(regWrite_in), .memToReg_in(memToReg_in), .registerRT_in(registerRT_in),
    .ALU_Result(ALU_Result), .Mem_readData(Mem_readData),
    .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_registerRT(wb_registerRT),
    .wb_writeData(wb_writeData), .retired_count(retired_count)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .regWrite_in(regWrite_in), .memToReg_in(memToReg_in), .registerRT_in(registerRT_in),
    .ALU_Result(ALU_Result), .Mem_readData(Mem_readData),
    .wb_valid(s_valid), .wb_regWrite(s_regWrite), .wb_registerRT(s_registerRT),
    .wb_writeData(s_writeData), .retired_count(s_count)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pat_a5 = {16{8'hA5}};
    pat_12 = {8{16'h1234}};
    pat_x1 = {4{32'hDEAD_0001}};
    pat_x2 = {4{32'hBEEF_0002}};

    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b1; regWrite_in = 1'b1; memToReg_in = 1'b0;
    registerRT_in = 7'd45; ALU_Result = pat_a5; Mem_readData = pat_12;
    step(); step();
    chk("rst_valid", wb_valid, 0);
    chk("rst_regw", wb_regWrite, 0);
    chk("rst_rt", wb_registerRT, 0);
    chk("rst_data", wb_writeData, 0);
    chk("rst_cnt", retired_count, 0);
    chk("rst_cnt4", s_count, 0);

    reset = 1'b1;
    step();
    chk("alu_data", wb_writeData, pat_a5);
    chk("alu_rt", wb_registerRT, 45);
    chk("alu_regw", wb_regWrite, 1);
    chk("alu_valid", wb_valid, 1);
    chk("alu_cnt", retired_count, 1);

    memToReg_in = 1'b1;
    step();
    chk("mem_data", wb_writeData, pat_12);
    chk("mem_cnt", retired_count, 2);

    memToReg_in = 1'b0; registerRT_in = 7'd10; ALU_Result = pat_x1;
    step();
    chk("cap10_rt", wb_registerRT, 10);
    chk("cap10_cnt", retired_count, 3);

    stall = 1'b1; registerRT_in = 7'd20; ALU_Result = pat_x2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rt", wb_registerRT, 10);
      chk("stall_data", wb_writeData, pat_x1);
      chk("stall_cnt", retired_count, 3);
    end
    stall = 1'b0;
    step();
    chk("unstall_rt", wb_registerRT, 20);
    chk("unstall_data", wb_writeData, pat_x2);
    chk("unstall_cnt", retired_count, 4);

    flush = 1'b1; registerRT_in = 7'd30;
    step();
    chk("flush_valid", wb_valid, 0);
    chk("flush_regw", wb_regWrite, 0);
    chk("flush_rt", wb_registerRT, 30);
    chk("flush_cnt", retired_count, 4);

    flush = 1'b0; registerRT_in = 7'd31;
    step();
    chk("post_flush_valid", wb_valid, 1);
    chk("post_flush_cnt", retired_count, 5);

    flush = 1'b1; stall = 1'b1; registerRT_in = 7'd32;
    step();
    chk("fl_st_rt", wb_registerRT, 31);
    chk("fl_st_valid", wb_valid, 1);
    chk("fl_st_regw", wb_regWrite, 1);
    chk("fl_st_cnt", retired_count, 5);

    flush = 1'b0; stall = 1'b0; in_valid = 1'b0; regWrite_in = 1'b1;
    step();
    chk("bubble_regw", wb_regWrite, 0);
    chk("bubble_valid", wb_valid, 0);
    chk("bubble_cnt", retired_count, 5);

    in_valid = 1'b1; regWrite_in = 1'b0;
    step();
    chk("store_valid", wb_valid, 1);
    chk("store_regw", wb_regWrite, 0);
    chk("store_cnt", retired_count, 6);

    // Mid-operation reset with a live writing instruction at the input.
    regWrite_in = 1'b1; reset = 1'b0;
    step();
    chk("mrst_regw", wb_regWrite, 0);
    chk("mrst_cnt", retired_count, 0);
    chk("mrst_cnt4", s_count, 0);
    reset = 1'b1; in_valid = 1'b0;
    step();
    chk("mrst_after_regw", wb_regWrite, 0);
    chk("mrst_after_cnt4", s_count, 0);

    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      registerRT_in = REG_W'(i);
      step();
      chk("sat_rt", wb_registerRT, i);
      chk("sat_cnt4", s_count, (i + 1 > 15) ? 15 : i + 1);
      chk("sat_cnt32", retired_count, i + 1);
    end
    chk("sat_hold", s_count, 15);

    reset = 1'b0;
    step();
    chk("sat_rst_cnt4", s_count, 0);
    reset = 1'b1;
    step();
    chk("sat_restart_cnt4", s_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
